// File: rtl/alu_ctrl_mdu_if.sv
// rtl/alu_ctrl_mdu_if.sv - issue/result bundle between datapath and alu_ctrl_mdu
interface alu_ctrl_mdu_if #(
    parameter int WIDTH  = 32,
    parameter int CTRL_W = 4
);
    logic              valid;
    logic [3:0]        ALUOp;
    logic [5:0]        funct;
    logic [WIDTH-1:0]  srcA;
    logic [WIDTH-1:0]  srcB;
    logic [CTRL_W-1:0] ALUControl;
    logic              mdu_sel;
    logic [WIDTH-1:0]  mdu_result;
    logic              stall;
    logic              busy;
    logic              done;
    logic [WIDTH-1:0]  hi;
    logic [WIDTH-1:0]  lo;

    modport master (
        output valid, ALUOp, funct, srcA, srcB,
        input  ALUControl, mdu_sel, mdu_result, stall, busy, done, hi, lo
    );

    modport slave (
        input  valid, ALUOp, funct, srcA, srcB,
        output ALUControl, mdu_sel, mdu_result, stall, busy, done, hi, lo
    );
endinterface

// File: rtl/alu_ctrl_mdu.sv
// rtl/alu_ctrl_mdu.sv - ALU control decode plus iterative HI/LO multiply/divide unit
// Define MDU_SIGNED_EN to make mult/div signed; otherwise they behave as multu/divu.
module alu_ctrl_mdu #(
    parameter int WIDTH  = 32,
    parameter int CTRL_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    alu_ctrl_mdu_if.slave    bus
);
    localparam int CNT_W = $clog2(WIDTH + 1);

    localparam logic [5:0] F_MFHI  = 6'b010000;
    localparam logic [5:0] F_MTHI  = 6'b010001;
    localparam logic [5:0] F_MFLO  = 6'b010010;
    localparam logic [5:0] F_MTLO  = 6'b010011;
    localparam logic [5:0] F_MULT  = 6'b011000;
    localparam logic [5:0] F_MULTU = 6'b011001;
    localparam logic [5:0] F_DIV   = 6'b011010;
    localparam logic [5:0] F_DIVU  = 6'b011011;

    typedef enum logic {S_IDLE, S_RUN} state_t;
    state_t r_state, w_state_nx;

    logic [2*WIDTH-1:0] r_acc;
    logic [WIDTH-1:0]   r_b;
    logic [WIDTH-1:0]   r_hi, r_lo;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_is_div, r_dz, r_neg_q, r_neg_r, r_busy, r_done;

    logic [3:0] w_ctrl;
    logic       w_rtype, w_is_mul, w_is_div, w_is_arith, w_is_mdu_funct;
    logic       w_stall, w_accept_op, w_finish, w_signed_op, w_neg_a, w_neg_b, w_dz;
    logic       w_is_mfhi, w_is_mflo;
    logic [WIDTH-1:0]   w_mag_a, w_mag_b, w_q, w_r, w_wb_hi, w_wb_lo;
    logic [WIDTH:0]     w_sum, w_trial;
    logic [2*WIDTH-1:0] w_mul_nx, w_div_nx, w_step, w_prod;

    always_comb begin
        w_ctrl = 4'b0010;
        if (bus.ALUOp == 4'b0000) begin
            case (bus.funct)
                6'b000000, 6'b000100: w_ctrl = 4'b0011;
                6'b000010, 6'b000110: w_ctrl = 4'b0100;
                6'b000011, 6'b000111: w_ctrl = 4'b0101;
                6'b100000:            w_ctrl = 4'b0010;
                6'b100010:            w_ctrl = 4'b0110;
                6'b100100:            w_ctrl = 4'b0000;
                6'b100101:            w_ctrl = 4'b0001;
                6'b100110:            w_ctrl = 4'b1011;
                6'b100111:            w_ctrl = 4'b1100;
                6'b101010:            w_ctrl = 4'b0111;
                6'b101011:            w_ctrl = 4'b1111;
                default:              w_ctrl = 4'b0010;
            endcase
        end else begin
            case (bus.ALUOp)
                4'b0100: w_ctrl = 4'b0110;
                4'b0101: w_ctrl = 4'b1000;
                4'b1000: w_ctrl = 4'b0010;
                4'b1010: w_ctrl = 4'b0111;
                4'b1011: w_ctrl = 4'b1111;
                4'b1100: w_ctrl = 4'b0000;
                4'b1101: w_ctrl = 4'b0001;
                4'b1110: w_ctrl = 4'b1011;
                default: w_ctrl = 4'b0010;
            endcase
        end
    end

    assign w_rtype        = (bus.ALUOp == 4'b0000);
    assign w_is_mul       = w_rtype & ((bus.funct == F_MULT) | (bus.funct == F_MULTU));
    assign w_is_div       = w_rtype & ((bus.funct == F_DIV)  | (bus.funct == F_DIVU));
    assign w_is_arith     = w_is_mul | w_is_div;
    assign w_is_mdu_funct = w_rtype & (bus.funct[5:2] == 4'b0110 || bus.funct[5:2] == 4'b0100);
    assign w_is_mfhi      = bus.valid & w_rtype & (bus.funct == F_MFHI);
    assign w_is_mflo      = bus.valid & w_rtype & (bus.funct == F_MFLO);

    assign w_stall     = bus.valid & w_is_mdu_funct & (r_busy | (r_state == S_RUN));
    assign w_accept_op = bus.valid & w_is_arith & ~w_stall;
    assign w_dz        = w_is_div & (bus.srcB == '0);

`ifdef MDU_SIGNED_EN
    assign w_signed_op = (bus.funct == F_MULT) | (bus.funct == F_DIV);
`else
    assign w_signed_op = 1'b0;
`endif
    assign w_neg_a = w_signed_op & bus.srcA[WIDTH-1];
    assign w_neg_b = w_signed_op & bus.srcB[WIDTH-1];
    assign w_mag_a = w_neg_a ? -bus.srcA : bus.srcA;
    assign w_mag_b = w_neg_b ? -bus.srcB : bus.srcB;

    // Multiply: r_acc = {partial, multiplier}; divide: r_acc = {remainder, quotient}.
    assign w_sum    = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_b} : '0);
    assign w_mul_nx = {w_sum, r_acc[WIDTH-1:1]};
    assign w_trial  = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]} - {1'b0, r_b};
    assign w_div_nx = w_trial[WIDTH] ? {r_acc[2*WIDTH-2:0], 1'b0}
                                     : {w_trial[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1};
    assign w_step   = r_dz ? r_acc : (r_is_div ? w_div_nx : w_mul_nx);

    assign w_prod = r_neg_q ? -w_step : w_step;
    assign w_q    = r_neg_q ? -w_step[WIDTH-1:0] : w_step[WIDTH-1:0];
    assign w_r    = r_neg_r ? -w_step[2*WIDTH-1:WIDTH] : w_step[2*WIDTH-1:WIDTH];

    always_comb begin
        w_wb_hi = w_prod[2*WIDTH-1:WIDTH];
        w_wb_lo = w_prod[WIDTH-1:0];
        if (r_dz) begin
            w_wb_hi = r_acc[2*WIDTH-1:WIDTH];
            w_wb_lo = r_acc[WIDTH-1:0];
        end else if (r_is_div) begin
            w_wb_hi = w_r;
            w_wb_lo = w_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_nx;
    end

    always_comb begin
        w_state_nx = r_state;
        w_finish   = 1'b0;
        case (r_state)
            S_IDLE: if (w_accept_op) w_state_nx = S_RUN;
            S_RUN: begin
                if (r_cnt == CNT_W'(1)) begin
                    w_finish   = 1'b1;
                    w_state_nx = S_IDLE;
                end
            end
            default: w_state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc    <= '0;
            r_b      <= '0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_cnt    <= '0;
            r_is_div <= 1'b0;
            r_dz     <= 1'b0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_done <= w_finish;
            if (w_accept_op) begin
                r_busy   <= 1'b1;
                r_is_div <= w_is_div;
                r_dz     <= w_dz;
                r_neg_q  <= w_neg_a ^ w_neg_b;
                r_neg_r  <= w_neg_a;
                r_cnt    <= w_dz ? CNT_W'(1) : CNT_W'(WIDTH);
                r_b      <= w_is_div ? w_mag_b : w_mag_a;
                if (w_dz)          r_acc <= {bus.srcA, {WIDTH{1'b1}}};
                else if (w_is_div) r_acc <= {{WIDTH{1'b0}}, w_mag_a};
                else               r_acc <= {{WIDTH{1'b0}}, w_mag_b};
            end else if (r_state == S_RUN) begin
                r_acc <= w_step;
                r_cnt <= r_cnt - CNT_W'(1);
                if (w_finish) begin
                    r_busy <= 1'b0;
                    r_hi   <= w_wb_hi;
                    r_lo   <= w_wb_lo;
                end
            end
            if (bus.valid && !w_stall && w_rtype && bus.funct == F_MTHI) r_hi <= bus.srcA;
            if (bus.valid && !w_stall && w_rtype && bus.funct == F_MTLO) r_lo <= bus.srcA;
        end
    end

    assign bus.ALUControl = CTRL_W'(w_ctrl);
    assign bus.mdu_sel    = w_is_mfhi | w_is_mflo;
    assign bus.mdu_result = w_is_mfhi ? r_hi : (w_is_mflo ? r_lo : '0);
    assign bus.stall      = w_stall;
    assign bus.busy       = r_busy;
    assign bus.done       = r_done;
    assign bus.hi         = r_hi;
    assign bus.lo         = r_lo;
endmodule

// File: tb/tb_alu_ctrl_mdu.sv
// tb/tb_alu_ctrl_mdu.sv - directed bench for alu_ctrl_mdu with HI/LO scoreboard
module tb_alu_ctrl_mdu;
    localparam logic [5:0] F_MFHI  = 6'b010000;
    localparam logic [5:0] F_MTHI  = 6'b010001;
    localparam logic [5:0] F_MFLO  = 6'b010010;
    localparam logic [5:0] F_MTLO  = 6'b010011;
    localparam logic [5:0] F_MULT  = 6'b011000;
    localparam logic [5:0] F_MULTU = 6'b011001;
    localparam logic [5:0] F_DIV   = 6'b011010;
    localparam logic [5:0] F_DIVU  = 6'b011011;
    localparam logic [5:0] F_ADD   = 6'b100000;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_err = 0;
    int   n_done = 0;
    logic [63:0] sb[$];

    alu_ctrl_mdu_if #(.WIDTH(32), .CTRL_W(4)) bus ();

    alu_ctrl_mdu #(.WIDTH(32), .CTRL_W(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] model(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
        logic        sgn;
        logic [63:0] r;
        sgn = 1'b0;
`ifdef MDU_SIGNED_EN
        sgn = (f == F_MULT) || (f == F_DIV);
`endif
        if (f == F_MULT || f == F_MULTU) begin
            if (sgn) r = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
            else     r = {32'b0, a} * {32'b0, b};
        end else if (b == 32'd0) begin
            r = {a, 32'hFFFF_FFFF};
        end else if (sgn) begin
            r = {$signed(a) % $signed(b), $signed(a) / $signed(b)};
        end else begin
            r = {a % b, a / b};
        end
        return r;
    endfunction

    task automatic issue(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
        bus.valid = 1'b1;
        bus.ALUOp = 4'b0000;
        bus.funct = f;
        bus.srcA  = a;
        bus.srcB  = b;
        if (f == F_MULT || f == F_MULTU || f == F_DIV || f == F_DIVU) sb.push_back(model(f, a, b));
        @(posedge clk);
        #1;
        bus.valid = 1'b0;
        bus.funct = 6'b0;
    endtask

    task automatic wait_done(input string tag, input int exp_busy);
        int cnt;
        cnt = 0;
        @(negedge clk);
        while (bus.busy && cnt < 100) begin
            cnt++;
            @(negedge clk);
        end
        chk({tag, "_busy_cycles"}, 64'(cnt), 64'(exp_busy));
        chk({tag, "_done"}, 64'(bus.done), 64'd1);
    endtask

    always @(negedge clk) begin
        if (rst_n && bus.done) begin
            n_done++;
            if (sb.size() == 0) chk("sb_unexpected_done", 64'd1, 64'd0);
            else chk("sb_hilo", {bus.hi, bus.lo}, sb.pop_front());
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        logic [13:0] tbl [12];
        logic [31:0] exp_lo;
        int cnt;
        tbl = '{ {4'b0000, 6'b000000, 4'b0011}, {4'b0000, 6'b000110, 4'b0100},
                 {4'b0000, 6'b000111, 4'b0101}, {4'b0000, 6'b100010, 4'b0110},
                 {4'b0000, 6'b100111, 4'b1100}, {4'b0000, 6'b101011, 4'b1111},
                 {4'b0000, 6'b011010, 4'b0010}, {4'b0000, 6'b111111, 4'b0010},
                 {4'b0100, 6'b000000, 4'b0110}, {4'b0101, 6'b000000, 4'b1000},
                 {4'b1110, 6'b000000, 4'b1011}, {4'b0111, 6'b000000, 4'b0010} };
        bus.valid = 1'b0;
        bus.ALUOp = 4'b0;
        bus.funct = 6'b0;
        bus.srcA  = 32'b0;
        bus.srcB  = 32'b0;
        #2;
        chk("rst_hi", 64'(bus.hi), 64'd0);
        chk("rst_lo", 64'(bus.lo), 64'd0);
        chk("rst_busy_done", {bus.busy, bus.done, bus.stall, bus.mdu_sel}, 64'd0);
        chk("rst_mdu_result", 64'(bus.mdu_result), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 12; i++) begin
            bus.ALUOp = tbl[i][13:10];
            bus.funct = tbl[i][9:4];
            #1;
            chk($sformatf("decode_%0d", i), 64'(bus.ALUControl), 64'(tbl[i][3:0]));
        end

        bus.ALUOp = 4'b0000;
        bus.funct = F_MULT;
        bus.valid = 1'b0;
        bus.srcA  = 32'd3;
        bus.srcB  = 32'd4;
        @(posedge clk);
        #1;
        chk("invalid_mult_busy", {bus.busy, bus.stall}, 64'd0);
        @(negedge clk);
        chk("invalid_mult_no_done", 64'(bus.done), 64'd0);

        issue(F_MULT, 32'd7, 32'hFFFF_FFFD);
        wait_done("mult", 32);
        issue(F_DIVU, 32'd100, 32'd7);
        chk("done_cycle_accept", {bus.busy, bus.done}, 64'b10);
        wait_done("divu", 32);
        chk("divu_lo", 64'(bus.lo), 64'd14);
        chk("divu_hi", 64'(bus.hi), 64'd2);
        @(negedge clk);
        chk("done_single_pulse", 64'(bus.done), 64'd0);
        issue(F_DIV, 32'hFFFF_FFF9, 32'd2);
        wait_done("div", 32);
        issue(F_DIV, 32'd5, 32'd0);
        wait_done("divzero", 1);
        chk("divzero_hilo", {bus.hi, bus.lo}, {32'd5, 32'hFFFF_FFFF});

        exp_lo = model(F_MULTU, 32'h1234_5678, 32'h9ABC_DEF0);
        issue(F_MULTU, 32'h1234_5678, 32'h9ABC_DEF0);
        @(negedge clk);
        bus.valid = 1'b1;
        bus.funct = F_ADD;
        #1;
        chk("add_no_stall", 64'(bus.stall), 64'd0);
        chk("add_ctrl", 64'(bus.ALUControl), 64'b0010);
        @(negedge clk);
        @(negedge clk);
        bus.funct = F_MFLO;
        #1;
        chk("mflo_stall", 64'(bus.stall), 64'd1);
        cnt = 0;
        while (bus.stall && cnt < 100) begin
            @(negedge clk);
            cnt++;
        end
        chk("mflo_stall_cycles", 64'(cnt), 64'd30);
        chk("mflo_done_cycle", {bus.done, bus.mdu_sel}, 64'b11);
        chk("mflo_result", 64'(bus.mdu_result), 64'(exp_lo));
        @(posedge clk);
        #1;
        bus.valid = 1'b0;
        bus.funct = 6'b0;

        issue(F_MTHI, 32'hCAFE_BABE, 32'd0);
        bus.valid = 1'b1;
        bus.funct = F_MFHI;
        #1;
        chk("mfhi_no_stall", 64'(bus.stall), 64'd0);
        chk("mfhi_sel_result", {bus.mdu_sel, bus.mdu_result}, {1'b1, 32'hCAFE_BABE});
        @(posedge clk);
        #1;
        bus.valid = 1'b0;
        bus.funct = 6'b0;

        issue(F_MULTU, 32'h11, 32'h22);
        repeat (10) @(negedge clk);
        rst_n = 1'b0;
        #1;
        sb.delete();
        chk("abort_busy_done", {bus.busy, bus.done}, 64'd0);
        chk("abort_hilo", {bus.hi, bus.lo}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        issue(F_MTLO, 32'h1234, 32'd0);
        bus.valid = 1'b1;
        bus.funct = F_MFLO;
        #1;
        chk("mtlo_mflo", 64'(bus.mdu_result), 64'h1234);
        @(posedge clk);
        #1;
        bus.valid = 1'b0;
        bus.funct = 6'b0;
        repeat (40) @(negedge clk);
        chk("no_done_after_abort", {32'(n_done), 32'(sb.size())}, {32'd5, 32'd0});
        chk("idle_at_end", 64'(bus.busy), 64'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
        $finish;
    end
endmodule

// File: doc/alu_ctrl_mdu.md
# alu_ctrl_mdu

Parametrised successor to the single-cycle ALU control decoder. It keeps the ALUOp/funct decode that drives the ALU. It adds an iterative multiply/divide unit (MDU) with architectural HI/LO registers for mult/multu/div/divu/mfhi/mflo/mthi/mtlo, and a stall output that freezes the issuing stage while the MDU is busy. It sits in the datapath between the main control unit, the register-file read ports and the writeback mux.

## Interface
- WIDTH, 32: operand, HI and LO width in bits (even, ≥ 8).
- CTRL_W, 4: ALUControl width.
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- valid  in  1  instruction in the issue stage is valid.
- ALUOp  in  4  opcode-derived ALU operation class.
- funct  in  6  R-type funct field.
- srcA  in  WIDTH  rs value: dividend or multiplicand; mthi/mtlo source.
- srcB  in  WIDTH  rt value: divisor or multiplier.
- ALUControl  out  CTRL_W  ALU operation select, combinational.
- mdu_sel  out  1  1 when the writeback value comes from mdu_result (mfhi/mflo).
- mdu_result  out  WIDTH  HI for mfhi, LO for mflo, else 0.
- stall  out  1  issue stage must hold; combinational.
- busy  out  1  MDU iterating.
- done  out  1  one-cycle pulse when HI/LO take a new product or quotient.
- hi, lo  out  WIDTH  architectural HI/LO.

## Operation
- ALUControl decode:
  - ALUOp 0000, funct: sll/sllv→0011; srl/srlv→0100; sra/srav→0101; add→0010; sub→0110; and→0000; or→0001; xor→1011; nor→1100; slt→0111; sltu→1111.
  - ALUOp: 0100→0110; 0101→1000; 1000→0010; 1010→0111; 1011→1111; 1100→0000; 1101→0001; 1110→1011.
  - Any other ALUOp→0010.
  - MDU functs and unlisted functs→0010; no X outputs.
- MDU functs (ALUOp 0000): mult 011000, multu 011001, div 011010, divu 011011, mfhi 010000, mthi 010001, mflo 010010, mtlo 010011.
- State machine IDLE → RUN → IDLE:
  - IDLE: a valid mult/multu/div/divu with stall=0 is accepted. Operand magnitudes (signed ops) or raw values are latched, the result sign is latched, and the state goes to RUN.
  - RUN: one radix-2 step per cycle; shift-add for multiply, restoring for divide. The count runs WIDTH down to 1. On the last step HI/LO are written with the sign-corrected result, done=1, and the state returns to IDLE.
- Multiply result: {HI,LO} = 2·WIDTH-bit product.
- Divide result: LO = quotient truncated toward zero; HI = remainder, taking the sign of the dividend.
- Divide by zero: no iteration. HI = srcA, LO = all ones, written one cycle after accept with done=1.
- mthi/mtlo write srcA into HI/LO on the accept edge. mfhi/mflo drive mdu_result and mdu_sel combinationally.
- stall = valid & MDU funct & (busy | state==RUN). Non-MDU instructions never stall. A stalled instruction is not accepted and has no side effect.

## Timing
- Reset: state IDLE; hi, lo, busy, done, mdu_result, mdu_sel, stall = 0.
- Reset is asynchronous and may be asserted mid-RUN: the operation is aborted and HI/LO are cleared.
- Accept on edge E0. busy=1 from E0 through E_WIDTH. HI/LO are valid and done=1 in the cycle after E_WIDTH.
- Total latency is WIDTH+1 cycles from the accept cycle to first use via mfhi.
- Divide by zero: busy for one cycle; done in the cycle after E1.
- A new MDU op presented in the done cycle is accepted (state is IDLE).
- mfhi in the done cycle returns the new HI.
- mthi/mtlo take effect on their edge; mfhi on the next cycle sees the new value.
- Back-to-back mthi then mfhi in consecutive cycles needs no stall.

## Configuration
- MDU_SIGNED_EN defined: mult and div are signed, with two's-complement magnitude conversion at accept and negation at writeback.
- MDU_SIGNED_EN undefined: the sign logic is removed and mult/div behave exactly as multu/divu.

## Test plan
- ALUOp 0000 funct 100111 → ALUControl 1100. ALUOp 0111 → 0010. funct 011000 with valid=0 → no MDU activity.
- WIDTH=32, MDU_SIGNED_EN: mult 7, 0xFFFFFFFD → busy for 32 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFEB, done pulses once.
- divu 100, 7 → lo=14, hi=2 after 33 cycles. div 0xFFFFFFF9 (−7), 2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- div 5, 0 → done in the cycle after accept; hi=5, lo=0xFFFFFFFF; busy for exactly 1 cycle.
- mflo issued 3 cycles after mult → stall=1 until done. Then mdu_sel=1 and mdu_result=lo; add issued during busy → stall=0.
- rst_n low at cycle 10 of a mult → busy=0, hi=lo=0 immediately. A subsequent mtlo 0x1234 then mflo → 0x1234.
